// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 demultiplexer: routes each valid word to lane a/b/c/d chosen by
// {s1,s0} or a round-robin pointer, with per-lane valid pulses and saturating counts.
module demux_1x4_reg #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     din,
  input  logic             s0,
  input  logic             s1,
  input  logic             mode,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [W-1:0]     c,
  output logic [W-1:0]     d,
  output logic             va,
  output logic             vb,
  output logic             vc,
  output logic             vd,
  output logic [1:0]       ptr,
  output logic [CNT_W-1:0] ca,
  output logic [CNT_W-1:0] cb,
  output logic [CNT_W-1:0] cc,
  output logic [CNT_W-1:0] cd
);

  logic [W-1:0]     lane_q [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [3:0]       vld_q;
  logic [1:0]       ptr_q;
  logic [1:0]       lane_sel;

  // Select pins are only looked at when a word is accepted, so X on them is harmless.
  assign lane_sel = mode ? ptr_q : {s1, s0};

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so the pointer used for lane_sel is the one before its own increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the lane "memory" is four plain registers, so clearing it on reset is
      // cheap and gives consumers a defined value before the first word.
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      vld_q <= '0;
      ptr_q <= '0;
    end else if (in_valid) begin
      lane_q[lane_sel] <= din;
      vld_q            <= 4'b0001 << lane_sel;
      if (cnt_q[lane_sel] != {CNT_W{1'b1}})
        cnt_q[lane_sel] <= cnt_q[lane_sel] + 1'b1;
      if (mode)
        ptr_q <= ptr_q + 2'd1;
    end else begin
      vld_q <= '0;
    end
  end

  assign a   = lane_q[0];
  assign b   = lane_q[1];
  assign c   = lane_q[2];
  assign d   = lane_q[3];
  assign va  = vld_q[0];
  assign vb  = vld_q[1];
  assign vc  = vld_q[2];
  assign vd  = vld_q[3];
  assign ptr = ptr_q;
  assign ca  = cnt_q[0];
  assign cb  = cnt_q[1];
  assign cc  = cnt_q[2];
  assign cd  = cnt_q[3];

endmodule
